// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The cache uses the slave modport; the core/memory environment uses master.
interface icache_dm_if;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  pc, flush, mem_rdata, mem_ack,
    output instr, stall, mem_req, mem_addr
  );

  modport master (
    output pc, flush, mem_rdata, mem_ack,
    input  instr, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path, and an
// IDLE/FILL/DONE FSM that refills a whole line word by word over req/ack.
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input logic        clk,
  input logic        reset,
  icache_dm_if.slave bus
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 30 - OB - IB;
  localparam logic [OB-1:0] CNT_LAST = OB'(WORDS - 1);
  localparam logic [OB-1:0] CNT_ONE  = OB'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [LINES-1:0] valid_r;
  logic [TB-1:0]    tagArr_r  [LINES];
  logic [31:0]      dataArr_r [LINES*WORDS];
  logic [OB-1:0]    cnt_r;
  logic [IB-1:0]    fillIdx_r;
  logic [TB-1:0]    fillTag_r;
  logic             flushPend_r;
  logic             memReq_r;
  logic [31:0]      memAddr_r;

  logic [OB-1:0]    pcOff_s;
  logic [IB-1:0]    pcIdx_s;
  logic [TB-1:0]    pcTag_s;
  logic             hit_s;
  logic             lastAck_s;
  logic             unusedPcBits_s;

  assign pcOff_s        = bus.pc[2 +: OB];
  assign pcIdx_s        = bus.pc[2+OB +: IB];
  assign pcTag_s        = bus.pc[31 -: TB];
  assign unusedPcBits_s = ^bus.pc[1:0];

  // The lookup is only trusted in IDLE, so DONE always costs one stall cycle.
  assign hit_s = (state_r == IDLE) && valid_r[pcIdx_s] && (tagArr_r[pcIdx_s] == pcTag_s);
  assign lastAck_s = (state_r == FILL) && bus.mem_ack && (cnt_r == CNT_LAST);

  assign bus.stall    = ~hit_s;
  assign bus.instr    = hit_s ? dataArr_r[{pcIdx_s, pcOff_s}] : 32'h0000_0000;
  assign bus.mem_req  = memReq_r;
  assign bus.mem_addr = memAddr_r;

  // Control state: FSM, valid bits, fill counter and the memory request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      cnt_r       <= '0;
      fillIdx_r   <= '0;
      fillTag_r   <= '0;
      flushPend_r <= 1'b0;
      memReq_r    <= 1'b0;
      memAddr_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.flush) begin
            valid_r <= '0;
          end
          if (!hit_s) begin
            state_r   <= FILL;
            memReq_r  <= 1'b1;
            memAddr_r <= {bus.pc[31:2+OB], {OB{1'b0}}, 2'b00};
            fillIdx_r <= pcIdx_s;
            fillTag_r <= pcTag_s;
            cnt_r     <= '0;
          end
        end
        FILL: begin
          if (bus.flush) begin
            flushPend_r <= 1'b1;
          end
          if (bus.mem_ack) begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              state_r  <= DONE;
              memReq_r <= 1'b0;
              // A flush seen during the fill leaves the fresh line invalid too.
              if (flushPend_r || bus.flush) begin
                valid_r     <= '0;
                flushPend_r <= 1'b0;
              end else begin
                valid_r[fillIdx_r] <= 1'b1;
              end
            end else begin
              memAddr_r <= memAddr_r + 32'd4;
            end
          end
        end
        DONE: begin
          if (bus.flush) begin
            valid_r <= '0;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          memReq_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if ((state_r == FILL) && bus.mem_ack) begin
      dataArr_r[{fillIdx_r, cnt_r}] <= bus.mem_rdata;
    end
    if (lastAck_s) begin
      tagArr_r[fillIdx_r] <= fillTag_r;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: a word-addressed memory responder with
// configurable wait states checks fill addresses; fetched instructions are queued.
module tb_icache_dm;
  logic clk;
  logic reset;
  icache_dm_if bus ();

  icache_dm #(.LINES(16), .WORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checkCount = 0;
  int errorCount = 0;
  logic [31:0] expQ[$];
  logic [31:0] addrQ[$];
  int waitN = 0;
  int waitCnt = 0;
  int ackCount = 0;
  int fillAcks = 0;
  int flushAtAck = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Memory responder: acks every (waitN+1)th request cycle, checks addresses.
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.flush = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.flush = 1'b0;
      if (bus.mem_req === 1'b1 && !reset) begin
        if (addrQ.size() > 0) checkEq("memAddr", bus.mem_addr, addrQ[0]);
        else checkEq("unexpectedReq", {31'd0, bus.mem_req}, 32'd0);
        if (waitCnt >= waitN) begin
          waitCnt = 0;
          bus.mem_ack = 1'b1;
          bus.mem_rdata = memWord(bus.mem_addr);
          ackCount++;
          fillAcks++;
          if (addrQ.size() > 0) void'(addrQ.pop_front());
          if (flushAtAck != 0 && fillAcks == flushAtAck) begin
            bus.flush = 1'b1;
            flushAtAck = 0;
          end
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
        fillAcks = 0;
      end
    end
  end

  // Present pc from a negedge and hold it until the hit; nFills line fills expected.
  task automatic fetch(input logic [31:0] addr, input int expStall, input int nFills);
    int n;
    logic [31:0] base;
    logic [31:0] exp;
    base = {addr[31:4], 4'h0};
    for (int f = 0; f < nFills; f++)
      for (int w = 0; w < 4; w++) addrQ.push_back(base + 32'(w * 4));
    expQ.push_back(memWord({addr[31:2], 2'b00}));
    bus.pc = addr;
    n = 0;
    #1;
    while (bus.stall !== 1'b0 && n < 300) begin
      if (n == 0) checkEq("nopOnStall", bus.instr, 32'h0);
      n++;
      @(negedge clk);
      #1;
    end
    if (n >= 300) checkEq("hitTimeout", 32'(n), 32'd0);
    exp = expQ.pop_front();
    checkEq("instr", bus.instr, exp);
    checkEq("stallCycles", 32'(n), 32'(expStall));
    checkEq("reqOnHit", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int ackBase;
    int n;
    reset = 1'b1;
    bus.pc = 32'h0000_0010;
    repeat (3) @(negedge clk);
    #1;
    checkEq("rstStall", {31'd0, bus.stall}, 32'd1);
    checkEq("rstInstr", bus.instr, 32'h0);
    checkEq("rstReq", {31'd0, bus.mem_req}, 32'd0);
    checkEq("rstAddr", bus.mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Cold miss, then same-line hits.
    fetch(32'h0000_0010, 6, 1);
    fetch(32'h0000_001C, 0, 0);
    fetch(32'h0000_0014, 0, 0);

    // Conflict on index 1: evict and refill.
    fetch(32'h0000_0110, 6, 1);
    fetch(32'h0000_0010, 6, 1);

    // Wait states: ack every third cycle.
    waitN = 2;
    ackBase = ackCount;
    fetch(32'h0000_0044, 14, 1);
    checkEq("waitWords", 32'(ackCount - ackBase), 32'd4);
    waitN = 0;
    fetch(32'h0000_0048, 0, 0);

    // Flush at the 2nd ack: line not validated, so the fill repeats.
    flushAtAck = 2;
    fetch(32'h0000_0220, 12, 2);
    fetch(32'h0000_0010, 6, 1);
    fetch(32'h0000_0048, 6, 1);

    // Reset after the 2nd ack of a fill.
    addrQ.push_back(32'h0000_0330);
    addrQ.push_back(32'h0000_0334);
    ackBase = ackCount;
    bus.pc = 32'h0000_0330;
    n = 0;
    while (ackCount < ackBase + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) checkEq("ackTimeout", 32'(n), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    checkEq("midRstReq", {31'd0, bus.mem_req}, 32'd0);
    checkEq("midRstStall", {31'd0, bus.stall}, 32'd1);
    checkEq("midRstInstr", bus.instr, 32'h0);
    checkEq("midRstAddrQ", 32'(addrQ.size()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fetch(32'h0000_0010, 6, 1);
    fetch(32'h0000_0018, 0, 0);
    checkEq("addrQEmpty", 32'(addrQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
